// File: rtl/cc_transition_sequencer.sv
// Level-transition banner sequencer: drives the fixed-transition ROM code, strobes the
// init-register load, holds the banner for HOLD_TICKS frame ticks, then restores gameplay.
module cc_transition_sequencer #(
  parameter int HOLD_TICKS = 8,
  parameter int CNT_W      = 8
) (
  input  logic       CC_TRANSITIONSEQUENCER_CLOCK_50,
  input  logic       CC_TRANSITIONSEQUENCER_RESET_InHigh,
  input  logic       CC_TRANSITIONSEQUENCER_start_InHigh,
  input  logic [2:0] CC_TRANSITIONSEQUENCER_level_InBUS,
  input  logic       CC_TRANSITIONSEQUENCER_tick_InHigh,
  input  logic       CC_TRANSITIONSEQUENCER_skip_InHigh,
  output logic [2:0] CC_TRANSITIONSEQUENCER_transition_OutBUS,
  output logic       CC_TRANSITIONSEQUENCER_load_OutHigh,
  output logic       CC_TRANSITIONSEQUENCER_busy_OutHigh,
  output logic       CC_TRANSITIONSEQUENCER_done_OutHigh
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHOW    = 3'd1,
    S_HOLD    = 3'd2,
    S_RESTORE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_TICKS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       level_q, level_d;
  logic [2:0]       trans_q, trans_d;
  logic             load_q, load_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic             level_ok;

  assign accept   = (state_q == S_IDLE) && CC_TRANSITIONSEQUENCER_start_InHigh;
  assign level_ok = (CC_TRANSITIONSEQUENCER_level_InBUS >= 3'd1) &&
                    (CC_TRANSITIONSEQUENCER_level_InBUS <= 3'd5);

  always_ff @(posedge CC_TRANSITIONSEQUENCER_CLOCK_50) begin
    if (CC_TRANSITIONSEQUENCER_RESET_InHigh) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      level_q <= 3'd0;
      trans_q <= 3'd0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      trans_q <= trans_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          level_d = CC_TRANSITIONSEQUENCER_level_InBUS;
          state_d = level_ok ? S_SHOW : S_RESTORE;
        end
      end
      S_SHOW: begin
        cnt_d   = '0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        // skip wins; a coincident final tick still yields a single exit
        if (CC_TRANSITIONSEQUENCER_skip_InHigh ||
            (CC_TRANSITIONSEQUENCER_tick_InHigh && (cnt_q == LAST_CNT))) begin
          state_d = S_RESTORE;
        end else if (CC_TRANSITIONSEQUENCER_tick_InHigh) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESTORE: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so they are registered on entry.
  always_comb begin
    trans_d = 3'd0;
    load_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_d)
      S_SHOW: begin
        trans_d = level_d;
        load_d  = 1'b1;
        busy_d  = 1'b1;
      end
      S_HOLD: begin
        trans_d = level_d;
        busy_d  = 1'b1;
      end
      S_RESTORE: begin
        load_d = 1'b1;
        busy_d = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign CC_TRANSITIONSEQUENCER_transition_OutBUS = trans_q;
  assign CC_TRANSITIONSEQUENCER_load_OutHigh      = load_q;
  assign CC_TRANSITIONSEQUENCER_busy_OutHigh      = busy_q;
  assign CC_TRANSITIONSEQUENCER_done_OutHigh      = done_q;

endmodule

// File: tb/tb_cc_transition_sequencer.sv
// Directed bench for cc_transition_sequencer; outputs are checked as {transition, load, busy, done}.
module tb_cc_transition_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [2:0] level = 3'd0;
  logic       tick = 1'b0;
  logic       skip = 1'b0;
  logic [2:0] trans;
  logic       load;
  logic       busy;
  logic       done;

  int tests_run = 0;
  int tests_failed = 0;

  cc_transition_sequencer #(.HOLD_TICKS(8), .CNT_W(8)) dut (
    .CC_TRANSITIONSEQUENCER_CLOCK_50        (clk),
    .CC_TRANSITIONSEQUENCER_RESET_InHigh    (rst),
    .CC_TRANSITIONSEQUENCER_start_InHigh    (start),
    .CC_TRANSITIONSEQUENCER_level_InBUS     (level),
    .CC_TRANSITIONSEQUENCER_tick_InHigh     (tick),
    .CC_TRANSITIONSEQUENCER_skip_InHigh     (skip),
    .CC_TRANSITIONSEQUENCER_transition_OutBUS(trans),
    .CC_TRANSITIONSEQUENCER_load_OutHigh    (load),
    .CC_TRANSITIONSEQUENCER_busy_OutHigh    (busy),
    .CC_TRANSITIONSEQUENCER_done_OutHigh    (done)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then observed 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] e_tr, input logic e_ld,
                     input logic e_bs, input logic e_dn);
    logic [5:0] got;
    logic [5:0] exp;
    got = {trans, load, busy, done};
    exp = {e_tr, e_ld, e_bs, e_dn};
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed tr/ld/bs/dn=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic start_banner(input logic [2:0] lvl);
    start = 1'b1;
    level = lvl;
    cyc();
    start = 1'b0;
    chk("show", lvl, 1'b1, 1'b1, 1'b0);
    cyc();
    chk("hold_entry", lvl, 1'b0, 1'b1, 1'b0);
  endtask

  // n ticks spaced sp cycles apart, none of which ends the hold.
  task automatic hold_phase(input logic [2:0] lvl, input int n, input int sp);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < sp - 1; j++) begin
        tick = 1'b0;
        cyc();
        chk("hold_idle", lvl, 1'b0, 1'b1, 1'b0);
      end
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk("hold_tick", lvl, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic finish_seq(input logic t, input logic s);
    tick = t;
    skip = s;
    cyc();
    tick = 1'b0;
    skip = 1'b0;
    chk("restore", 3'd0, 1'b1, 1'b1, 1'b0);
    cyc();
    chk("done", 3'd0, 1'b0, 1'b1, 1'b1);
    cyc();
    chk("idle_after", 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [2:0] bad_lv [3];
    bad_lv[0] = 3'd0;
    bad_lv[1] = 3'd6;
    bad_lv[2] = 3'd7;

    // Reset state
    rst = 1'b1;
    cyc();
    chk("reset", 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick = 1'b1;
    skip = 1'b1;
    cyc();
    tick = 1'b0;
    skip = 1'b0;
    chk("idle_ignores_tick_skip", 3'd0, 1'b0, 1'b0, 1'b0);

    // 1: nominal level 3, tick every 4 cycles, 8 ticks
    start_banner(3'd3);
    hold_phase(3'd3, 7, 4);
    for (int j = 0; j < 3; j++) begin
      cyc();
      chk("hold_pre_last", 3'd3, 1'b0, 1'b1, 1'b0);
    end
    finish_seq(1'b1, 1'b0);

    // 2: skip after 2 ticks, level 5
    start_banner(3'd5);
    hold_phase(3'd5, 2, 4);
    finish_seq(1'b0, 1'b1);

    // 3: invalid levels go straight to restore
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      level = bad_lv[i];
      cyc();
      start = 1'b0;
      chk("inv_restore", 3'd0, 1'b1, 1'b1, 1'b0);
      cyc();
      chk("inv_done", 3'd0, 1'b0, 1'b1, 1'b1);
      cyc();
      chk("inv_idle", 3'd0, 1'b0, 1'b0, 1'b0);
    end

    // 4: start during HOLD and coincident with done is ignored
    start_banner(3'd1);
    hold_phase(3'd1, 1, 2);
    start = 1'b1;
    level = 3'd2;
    cyc();
    start = 1'b0;
    chk("lock_hold", 3'd1, 1'b0, 1'b1, 1'b0);
    skip = 1'b1;
    cyc();
    skip = 1'b0;
    chk("lock_restore", 3'd0, 1'b1, 1'b1, 1'b0);
    start = 1'b1;
    level = 3'd2;
    cyc();
    chk("lock_done", 3'd0, 1'b0, 1'b1, 1'b1);
    cyc();
    start = 1'b0;
    chk("lock_start_at_done", 3'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("lock_no_queue", 3'd0, 1'b0, 1'b0, 1'b0);

    // 5: reset mid-hold, then a normal run with a tick every cycle
    start_banner(3'd4);
    hold_phase(3'd4, 3, 1);
    rst = 1'b1;
    start = 1'b1;
    level = 3'd2;
    cyc();
    rst = 1'b0;
    start = 1'b0;
    chk("rst_midhold", 3'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("rst_stays_idle", 3'd0, 1'b0, 1'b0, 1'b0);
    start_banner(3'd1);
    hold_phase(3'd1, 7, 1);
    finish_seq(1'b1, 1'b0);

    // 6: tick and skip together on the final tick
    start_banner(3'd2);
    hold_phase(3'd2, 7, 1);
    finish_seq(1'b1, 1'b1);
    cyc();
    chk("no_extra_load", 3'd0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cc_transition_sequencer.md
# cc_transition_sequencer

Sequences the level-transition screens of the 8x8 matrix game. On a request from the main state machine it drives the 3-bit transition code into the fixed-transition pattern ROM and pulses a load strobe so the point and background init registers capture the level banner. It holds the banner for a programmable number of frame ticks, then restores the code to the gameplay pattern (000), re-loads, and reports completion. It sits between the main state machine and the fixed-transition ROM / init-register bank.

## Interface

**Parameters**
- HOLD_TICKS, default 8: frame ticks the banner stays on screen (1..255).
- CNT_W, default 8: hold counter width; HOLD_TICKS < 2^CNT_W.

**Ports**
- CC_TRANSITIONSEQUENCER_CLOCK_50, in, 1: system clock; only clock.
- CC_TRANSITIONSEQUENCER_RESET_InHigh, in, 1: reset, synchronous, active-high.
- CC_TRANSITIONSEQUENCER_start_InHigh, in, 1: one-cycle request to show a banner.
- CC_TRANSITIONSEQUENCER_level_InBUS, in, 3: banner code sampled with start (1..5 valid).
- CC_TRANSITIONSEQUENCER_tick_InHigh, in, 1: one-cycle frame-tick enable.
- CC_TRANSITIONSEQUENCER_skip_InHigh, in, 1: ends the hold early (user button, already debounced).
- CC_TRANSITIONSEQUENCER_transition_OutBUS, out, 3: code to the ROM select input (STATEMACHINE_MAIN_transition_cwire).
- CC_TRANSITIONSEQUENCER_load_OutHigh, out, 1: one-cycle strobe; init registers capture the ROM outputs.
- CC_TRANSITIONSEQUENCER_busy_OutHigh, out, 1: high from accept until done.
- CC_TRANSITIONSEQUENCER_done_OutHigh, out, 1: one-cycle completion pulse.

## Operation

- States: IDLE, SHOW, HOLD, RESTORE, DONE.
- **IDLE**
  - transition_OutBUS = 000; load, busy and done low.
  - start high: latch level.
    - If level is in 1..5, go to SHOW.
    - If level is 0, 6 or 7, go to RESTORE (no banner).
  - busy rises on the cycle after the start is accepted.
- **SHOW**
  - transition_OutBUS = latched level. The register is updated on entry, so the ROM is already stable.
  - load = 1 for this single cycle.
  - Clear the hold counter. Next state HOLD.
- **HOLD**
  - transition_OutBUS holds the level; load low.
  - Each tick increments the counter.
  - Leave when counter == HOLD_TICKS - 1 and tick is high, or when skip is high (skip has priority). Next state RESTORE.
- **RESTORE**
  - transition_OutBUS = 000, registered on entry.
  - load = 1 for one cycle. Next state DONE.
- **DONE**
  - done = 1 for one cycle; busy drops on exit. Next state IDLE.
- start while busy is ignored and is not queued.
- tick outside HOLD is ignored.
- skip outside HOLD is ignored.
- All outputs are registered and glitch-free.
- The ROM is combinational, so load is asserted in the same cycle its code is valid at the register output.

## Timing

- Reset (synchronous, sampled on the clock edge):
  - state = IDLE, counter = 0, latched level = 000.
  - transition_OutBUS = 000; load, busy, done all 0.
  - Reset mid-sequence aborts immediately. No restore load is issued; the main FSM is responsible for re-initialising.
- Start accepted at edge N:
  - SHOW during cycle N+1: code = level, load = 1, busy = 1.
- HOLD length: HOLD_TICKS tick pulses. Cycles between the two load strobes = 1 + cycles until the HOLD_TICKS-th tick + 1.
- The RESTORE load comes one cycle after the exiting tick or skip edge.
- done comes one cycle after the RESTORE load.
- Invalid-level path: start at N, then RESTORE load at N+1, done at N+2.
- Simultaneous events:
  - tick and skip together in HOLD: exit counted once.
  - start and reset together: reset wins.
  - start arriving the same cycle done is high: ignored, because the block is still busy. start is accepted only in IDLE.
- Counter never wraps: it is capped by the exit compare, and CNT_W is sized so HOLD_TICKS-1 fits.

## Test plan

1. **Nominal banner.** Reset, then start with level=3, with a tick every 4 cycles and HOLD_TICKS=8.
   - load pulses with transition=011 on cycle N+1.
   - After 8 ticks, load pulses with transition=000.
   - done pulses one cycle later.
   - busy is high over exactly that span.
2. **Skip.** Level=5; assert skip after 2 ticks.
   - RESTORE load (transition=000) occurs on the next cycle.
   - done follows; the counter value is irrelevant.
3. **Invalid levels.** Start with level=0, then 6, then 7.
   - No load with a non-zero code.
   - A single load with 000 at N+1, done at N+2.
4. **Busy lockout.** Issue a second start (level=2) during HOLD of level=1, and another start coincident with done.
   - Both are ignored: transition never shows 010, and only one done is seen.
5. **Reset mid-hold.** Assert reset during HOLD of level=4.
   - Next cycle: transition=000, busy=0, load=0, done=0.
   - A subsequent start with level=1 runs normally.
6. **Tick and skip coincident.** Tick and skip high together on the final tick.
   - Exactly one RESTORE load and one done; no extra load strobes.
